// File: rtl/xnor_parity_pkg.sv
// Shared types and sizing helpers for the XNOR3 parity arbiter.
// The default step count and counter width assume the default 16-bit word.
package xnor_parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Two word bits are folded per engine step.
    localparam int DEFAULT_W     = 16;
    localparam int DEFAULT_K     = DEFAULT_W / 2;
    localparam int DEFAULT_CNT_W = (clog2(DEFAULT_K) < 1) ? 1 : clog2(DEFAULT_K);

endpackage

// File: rtl/xnor_parity_arbiter_rr.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo NREQ, is returned one-hot and as an encoded index.
module rr_arbiter_xp #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NREQ]) begin
                any                               = 1'b1;
                grant[(int'(ptr) + i) % NREQ]     = 1'b1;
                idx                               = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/xnor_parity_arbiter.sv
// Round-robin front end feeding one serial XNOR3 parity engine; returns the
// XOR-reduction of each accepted word tagged with its requester index.
module xnor_parity_arbiter
    import xnor_parity_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic              res_par,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready,
    output logic              busy
);

    localparam int   K     = W / 2;
    localparam int   CNT_W = (clog2(K) < 1) ? 1 : clog2(K);
    localparam logic K_ODD = 1'(K % 2);

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    win;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              acc_next;
    logic [W-1:0]      data;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;

    rr_arbiter_xp #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // XNOR3 step; the data register shifts so the next pair is always at [1:0].
    assign acc_next  = ~(acc ^ data[0] ^ data[1]);
    assign req_ready = (rstb && state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            data      <= '0;
            res_valid <= 1'b0;
            res_par   <= 1'b0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        data  <= req_data[int'(grant_idx)*W +: W];
                        win   <= grant_idx;
                        acc   <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    data <= data >> 2;
                    cnt  <= cnt + 1'b1;
                    // An odd step count leaves one net inversion to undo.
                    if (cnt == CNT_W'(K - 1)) begin
                        res_par   <= acc_next ^ K_ODD;
                        res_id    <= win;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_parity_arbiter.sv
// Scoreboard bench: a reference round-robin model predicts each grant and
// queues the expected parity/ID, checked when the DUT hands the result off.
module tb_xnor_parity_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;
    localparam int K    = W / 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic           par;
        int             accCyc;
    } expect_t;

    logic              clk;
    logic              rstb;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_par;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              busy;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int acceptCount = 0;
    int resultCount = 0;
    int lastAccCyc  = 0;
    int hsCyc       = 0;
    int mPtr        = 0;
    bit mIdle       = 1'b1;
    bit prevValid   = 1'b0;
    expect_t        expQ[$];
    int             riseCyc[$];
    int             idLog[$];
    int             parLog[$];

    xnor_parity_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_par   (res_par),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Reference model runs on the falling edge, mid-cycle.
    always @(negedge clk) begin
        logic [NREQ-1:0] expGrant;
        int              expIdx;
        bit              found;
        expect_t         e;
        cyc++;
        if (!rstb) begin
            checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
            checkOutput("rst_req_ready", {28'b0, req_ready}, 32'd0);
            checkOutput("rst_busy", {31'b0, busy}, 32'd0);
            expQ.delete();
            mIdle     = 1'b1;
            mPtr      = 0;
            prevValid = 1'b0;
        end else begin
            expGrant = '0;
            expIdx   = 0;
            found    = 1'b0;
            if (mIdle) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req_valid[(mPtr + i) % NREQ]) begin
                        found              = 1'b1;
                        expIdx             = (mPtr + i) % NREQ;
                        expGrant[expIdx]   = 1'b1;
                    end
                end
            end
            checkOutput("req_ready", {28'b0, req_ready}, {28'b0, expGrant});
            checkOutput("busy", {31'b0, busy}, {31'b0, !mIdle});
            if (res_valid && !prevValid) begin
                riseCyc.push_back(cyc);
                if (expQ.size() == 0)
                    checkOutput("spurious_valid", {31'b0, res_valid}, 32'd0);
                else
                    checkOutput("latency", cyc - expQ[0].accCyc, K + 1);
            end
            if (res_valid && expQ.size() > 0) begin
                checkOutput("res_par", {31'b0, res_par}, {31'b0, expQ[0].par});
                checkOutput("res_id", {30'b0, res_id}, {30'b0, expQ[0].id});
                if (res_ready) begin
                    e = expQ.pop_front();
                    idLog.push_back(int'(res_id));
                    parLog.push_back(int'(res_par));
                    mPtr  = (int'(e.id) + 1) % NREQ;
                    hsCyc = cyc;
                    mIdle = 1'b1;
                    resultCount++;
                end
            end
            if (found) begin
                e.id     = IDW'(expIdx);
                e.par    = ^req_data[expIdx*W +: W];
                e.accCyc = cyc;
                expQ.push_back(e);
                mIdle      = 1'b0;
                lastAccCyc = cyc;
                acceptCount++;
            end
            prevValid = res_valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid);
        req_valid = valid;
    endtask

    task automatic setData(input int idx, input logic [W-1:0] value);
        req_data[idx*W +: W] = value;
    endtask

    task automatic waitAccept(input int target, input int budget);
        int n = 0;
        while (acceptCount < target && n < budget) begin
            tick();
            n++;
        end
        if (acceptCount < target) checkOutput("accept_timeout", acceptCount, target);
    endtask

    task automatic waitResults(input int target, input int budget);
        int n = 0;
        while (resultCount < target && n < budget) begin
            tick();
            n++;
        end
        if (resultCount < target) checkOutput("result_timeout", resultCount, target);
    endtask

    task automatic oneWord(input int idx, input logic [W-1:0] value);
        int a;
        int r;
        a = acceptCount;
        r = resultCount;
        setData(idx, value);
        applyStimulus(NREQ'(1) << idx);
        waitAccept(a + 1, 40);
        applyStimulus('0);
        waitResults(r + 1, 40);
    endtask

    initial begin
        int a0;
        int r0;
        int rise0;
        int n;
        logic [W-1:0] rv;
        int ri;

        rstb      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        tick(2);
        applyStimulus('1);
        tick();
        checkOutput("reset_req_ready", {28'b0, req_ready}, 32'd0);
        checkOutput("reset_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("reset_res_par", {31'b0, res_par}, 32'd0);
        checkOutput("reset_res_id", {30'b0, res_id}, 32'd0);
        applyStimulus('0);
        rstb = 1'b1;
        tick(2);

        $display("[TB] single request");
        oneWord(0, 16'h0007);
        checkOutput("single_par", parLog[parLog.size()-1], 32'd1);
        checkOutput("single_id", idLog[idLog.size()-1], 32'd0);

        $display("[TB] reset mid-run");
        r0    = resultCount;
        rise0 = riseCyc.size();
        setData(1, 16'hFFFF);
        applyStimulus(4'b0010);
        waitAccept(acceptCount + 1, 20);
        applyStimulus('0);
        tick(3);
        rstb = 1'b0;
        #1;
        checkOutput("async_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("async_res_par", {31'b0, res_par}, 32'd0);
        checkOutput("async_res_id", {30'b0, res_id}, 32'd0);
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_req_ready", {28'b0, req_ready}, 32'd0);
        tick(2);
        rstb = 1'b1;
        tick(15);
        checkOutput("no_stray_result", resultCount, r0);
        checkOutput("no_stray_valid", riseCyc.size(), rise0);

        $display("[TB] round robin");
        setData(0, 16'h1234);
        setData(1, 16'h8001);
        setData(2, 16'hFFFE);
        setData(3, 16'h0F0F);
        a0    = acceptCount;
        r0    = resultCount;
        rise0 = riseCyc.size();
        applyStimulus(4'b1111);
        waitAccept(a0 + 5, 80);
        applyStimulus('0);
        waitResults(r0 + 5, 80);
        checkOutput("rr_id0", idLog[r0], 32'd0);
        checkOutput("rr_id1", idLog[r0+1], 32'd1);
        checkOutput("rr_id2", idLog[r0+2], 32'd2);
        checkOutput("rr_id3", idLog[r0+3], 32'd3);
        checkOutput("rr_id4", idLog[r0+4], 32'd0);
        for (int i = 1; i < 5; i++)
            checkOutput("rr_spacing", riseCyc[rise0+i] - riseCyc[rise0+i-1], K + 2);

        $display("[TB] even parity");
        oneWord(2, 16'hA5A5);
        checkOutput("a5a5_par", parLog[parLog.size()-1], 32'd0);
        checkOutput("a5a5_id", idLog[idLog.size()-1], 32'd2);
        oneWord(2, 16'h0000);
        checkOutput("zero_par", parLog[parLog.size()-1], 32'd0);

        $display("[TB] wrap and drop");
        r0 = resultCount;
        setData(3, 16'h0001);
        setData(0, 16'h0003);
        setData(1, 16'hFFFF);
        applyStimulus(4'b1001);
        waitAccept(acceptCount + 1, 20);
        applyStimulus(4'b0011);
        tick(3);
        applyStimulus(4'b0001);
        waitAccept(acceptCount + 1, 40);
        applyStimulus('0);
        waitResults(r0 + 2, 40);
        checkOutput("wrap_first", idLog[r0], 32'd3);
        checkOutput("wrap_second", idLog[r0+1], 32'd0);
        tick(12);
        checkOutput("drop_no_result", resultCount, r0 + 2);

        $display("[TB] backpressure");
        res_ready = 1'b0;
        r0    = resultCount;
        rise0 = riseCyc.size();
        setData(2, 16'h00FF);
        setData(3, 16'h0301);
        applyStimulus(4'b0100);
        waitAccept(acceptCount + 1, 20);
        applyStimulus('0);
        n = 0;
        while (riseCyc.size() == rise0 && n < 30) begin
            tick();
            n++;
        end
        checkOutput("bp_rise", riseCyc.size(), rise0 + 1);
        applyStimulus(4'b1000);
        tick(5);
        checkOutput("bp_valid_held", {31'b0, res_valid}, 32'd1);
        checkOutput("bp_busy", {31'b0, busy}, 32'd1);
        checkOutput("bp_no_handshake", resultCount, r0);
        a0 = acceptCount;
        res_ready = 1'b1;
        waitAccept(a0 + 1, 20);
        applyStimulus('0);
        checkOutput("bp_one_handshake", resultCount, r0 + 1);
        checkOutput("bp_bubble", lastAccCyc - hsCyc, 32'd1);
        waitResults(r0 + 2, 40);
        checkOutput("bp_id", idLog[r0], 32'd2);

        $display("[TB] random words");
        for (int i = 0; i < 8; i++) begin
            rv = W'($urandom);
            ri = $urandom_range(NREQ - 1, 0);
            oneWord(ri, rv);
        end

        tick(5);
        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
